// File: rtl/blend_writer.sv
// Composites DVI/CCD RGB565 pixel pairs and packs them with coordinates into 36-bit
// frame-buffer write words, absorbing write-FIFO stalls in a small skid FIFO.
module blend_writer #(
   parameter int unsigned H_ACT = 640,
   parameter int unsigned V_ACT = 480,
   parameter int unsigned DEPTH = 4
) (
   input  logic        clk_25,
   input  logic        rst_n,
   input  logic        val,
   input  logic [9:0]  sync_x,
   input  logic [9:0]  sync_y,
   input  logic [4:0]  dvi_r,
   input  logic [5:0]  dvi_g,
   input  logic [4:0]  dvi_b,
   input  logic [4:0]  ccd_r,
   input  logic [5:0]  ccd_g,
   input  logic [4:0]  ccd_b,
   input  logic [1:0]  mode,
   input  logic [4:0]  alpha,
   input  logic        wrfull,
   output logic        wrclk,
   output logic        wrreq,
   output logic [35:0] wr_data,
   output logic        frame_done,
   output logic        overflow
);

   localparam int unsigned AW = $clog2(DEPTH);
   localparam logic [9:0] HALF_X = 10'(H_ACT / 2);
   localparam logic [9:0] LAST_X = 10'(H_ACT - 1);
   localparam logic [9:0] LAST_Y = 10'(V_ACT - 1);
   localparam logic [AW:0] FULL_CNT = (AW + 1)'(DEPTH);
   localparam logic [AW-1:0] PTR_ONE = AW'(1);
   localparam logic [AW:0] CNT_ONE = (AW + 1)'(1);

   assign wrclk = clk_25;

   // Shadow controls: only the frame-start pixel may load new settings, and it uses them itself.
   logic [1:0] mode_q, eff_mode;
   logic [4:0] alpha_q, eff_alpha, a_clamp, a_inv;
   logic       frame_start;

   assign frame_start = val && (sync_x == 10'd0) && (sync_y == 10'd0);
   assign eff_mode    = frame_start ? mode : mode_q;
   assign eff_alpha   = frame_start ? alpha : alpha_q;
   assign a_clamp     = (eff_alpha > 5'd16) ? 5'd16 : eff_alpha;
   assign a_inv       = 5'd16 - a_clamp;

   // Stage 1
   logic        s1_valid;
   logic [9:0]  s1_x, s1_y;
   logic [1:0]  s1_mode;
   logic [15:0] s1_dvi, s1_ccd;
   logic [9:0]  s1_pdr, s1_pdb, s1_pcr, s1_pcb;
   logic [10:0] s1_pdg, s1_pcg;

   always_ff @(posedge clk_25 or negedge rst_n) begin
      if (!rst_n) begin
         mode_q   <= 2'd0;
         alpha_q  <= 5'd0;
         s1_valid <= 1'b0;
         s1_x     <= '0;
         s1_y     <= '0;
         s1_mode  <= '0;
         s1_dvi   <= '0;
         s1_ccd   <= '0;
         s1_pdr   <= '0;
         s1_pdg   <= '0;
         s1_pdb   <= '0;
         s1_pcr   <= '0;
         s1_pcg   <= '0;
         s1_pcb   <= '0;
      end else begin
         if (frame_start) begin
            mode_q  <= mode;
            alpha_q <= alpha;
         end
         s1_valid <= val;
         s1_x     <= sync_x;
         s1_y     <= sync_y;
         s1_mode  <= eff_mode;
         s1_dvi   <= {dvi_r, dvi_g, dvi_b};
         s1_ccd   <= {ccd_r, ccd_g, ccd_b};
         s1_pdr   <= {5'd0, dvi_r} * {5'd0, a_inv};
         s1_pdg   <= {5'd0, dvi_g} * {6'd0, a_inv};
         s1_pdb   <= {5'd0, dvi_b} * {5'd0, a_inv};
         s1_pcr   <= {5'd0, ccd_r} * {5'd0, a_clamp};
         s1_pcg   <= {5'd0, ccd_g} * {6'd0, a_clamp};
         s1_pcb   <= {5'd0, ccd_b} * {5'd0, a_clamp};
      end
   end

   // Stage 2: sums never exceed 31*16 / 63*16, so the >>4 result fits without saturation.
   logic [9:0]  sum_r, sum_b;
   logic [10:0] sum_g;
   logic [15:0] colour;
   logic        s2_valid;
   logic [35:0] s2_word;

   assign sum_r = s1_pdr + s1_pcr;
   assign sum_g = s1_pdg + s1_pcg;
   assign sum_b = s1_pdb + s1_pcb;

   always_comb begin
      colour = s1_dvi;
      case (s1_mode)
         2'd0:    colour = s1_dvi;
         2'd1:    colour = s1_ccd;
         2'd2:    colour = {sum_r[8:4], sum_g[9:4], sum_b[8:4]};
         default: colour = (s1_x < HALF_X) ? s1_dvi : s1_ccd;
      endcase
   end

   always_ff @(posedge clk_25 or negedge rst_n) begin
      if (!rst_n) begin
         s2_valid <= 1'b0;
         s2_word  <= '0;
      end else begin
         s2_valid <= s1_valid;
         s2_word  <= {s1_x, s1_y, colour};
      end
   end

   // Skid FIFO and output register
   logic [35:0]   mem [DEPTH];
   logic [AW-1:0] wr_ptr_q, rd_ptr_q;
   logic [AW:0]   cnt_q;
   logic          empty, full, pop, bypass, push_req, push, drop;
   logic [35:0]   out_word;
   logic          wrreq_d, frame_done_d;

   assign empty    = (cnt_q == '0);
   assign full     = (cnt_q == FULL_CNT);
   assign pop      = !wrfull && !empty;
   assign bypass   = !wrfull && empty && s2_valid;
   assign push_req = s2_valid && !bypass;
   assign push     = push_req && (!full || pop);
   assign drop     = push_req && full && !pop;
   assign out_word = pop ? mem[rd_ptr_q] : s2_word;
   assign wrreq_d  = pop || bypass;
   assign frame_done_d = wrreq_d && (out_word[35:26] == LAST_X) && (out_word[25:16] == LAST_Y);

   always_ff @(posedge clk_25) begin
      if (push) mem[wr_ptr_q] <= s2_word;
   end

   always_ff @(posedge clk_25 or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr_q   <= '0;
         rd_ptr_q   <= '0;
         cnt_q      <= '0;
         wrreq      <= 1'b0;
         wr_data    <= '0;
         frame_done <= 1'b0;
         overflow   <= 1'b0;
      end else begin
         if (push) wr_ptr_q <= wr_ptr_q + PTR_ONE;
         if (pop)  rd_ptr_q <= rd_ptr_q + PTR_ONE;
         if (push && !pop)      cnt_q <= cnt_q + CNT_ONE;
         else if (pop && !push) cnt_q <= cnt_q - CNT_ONE;
         wrreq      <= wrreq_d;
         frame_done <= frame_done_d;
         if (wrreq_d) wr_data <= out_word;
         if (drop)    overflow <= 1'b1;
      end
   end

endmodule

// File: tb/tb_blend_writer.sv
// Directed self-checking bench for blend_writer: compositing modes, shadow controls,
// stall buffering, overflow, frame_done and mid-operation reset.
module tb_blend_writer;

   logic        clk_25 = 1'b0;
   logic        rst_n;
   logic        val;
   logic [9:0]  sync_x, sync_y;
   logic [4:0]  dvi_r, dvi_b, ccd_r, ccd_b;
   logic [5:0]  dvi_g, ccd_g;
   logic [1:0]  mode;
   logic [4:0]  alpha;
   logic        wrfull;
   logic        wrclk, wrreq, frame_done, overflow;
   logic [35:0] wr_data;

   int n_cmp = 0;
   int n_err = 0;
   logic [35:0] got_q[$];
   logic        fd_q[$];
   logic [35:0] exp_q[$];
   int          wr_while_full = 0;

   blend_writer dut (
      .clk_25     (clk_25),
      .rst_n      (rst_n),
      .val        (val),
      .sync_x     (sync_x),
      .sync_y     (sync_y),
      .dvi_r      (dvi_r),
      .dvi_g      (dvi_g),
      .dvi_b      (dvi_b),
      .ccd_r      (ccd_r),
      .ccd_g      (ccd_g),
      .ccd_b      (ccd_b),
      .mode       (mode),
      .alpha      (alpha),
      .wrfull     (wrfull),
      .wrclk      (wrclk),
      .wrreq      (wrreq),
      .wr_data    (wr_data),
      .frame_done (frame_done),
      .overflow   (overflow)
   );

   always #20 clk_25 = ~clk_25;

   always @(negedge clk_25) begin
      if (rst_n && wrreq) begin
         got_q.push_back(wr_data);
         fd_q.push_back(frame_done);
         if (wrfull) wr_while_full++;
      end
   end

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   function automatic logic [35:0] word(input int x, input int y, input int r, input int g,
                                        input int b);
      return {10'(x), 10'(y), 5'(r), 6'(g), 5'(b)};
   endfunction

   task automatic drive(input int x, input int y, input int dr, input int dg, input int db,
                        input int cr, input int cg, input int cb, input int m, input int a);
      sync_x = 10'(x); sync_y = 10'(y);
      dvi_r = 5'(dr); dvi_g = 6'(dg); dvi_b = 5'(db);
      ccd_r = 5'(cr); ccd_g = 6'(cg); ccd_b = 5'(cb);
      mode = 2'(m); alpha = 5'(a);
      val = 1'b1;
      @(posedge clk_25); #1;
      val = 1'b0;
   endtask

   task automatic idle(input int n);
      val = 1'b0;
      repeat (n) @(posedge clk_25);
      #1;
   endtask

   task automatic clear_q();
      got_q.delete(); fd_q.delete(); exp_q.delete();
   endtask

   // Compares captured words (and frame_done flags) against the expected list, then clears.
   task automatic compare_queue(input string tag);
      logic [63:0] g;
      logic        fd_exp;
      check({tag, "_count"}, 64'(got_q.size()), 64'(exp_q.size()));
      for (int i = 0; i < exp_q.size(); i++) begin
         g = (i < got_q.size()) ? 64'(got_q[i]) : 64'hdead_beef_dead;
         check($sformatf("%s_word%0d", tag, i), g, 64'(exp_q[i]));
         fd_exp = (exp_q[i][35:26] == 10'd639) && (exp_q[i][25:16] == 10'd479);
         g = (i < fd_q.size()) ? 64'(fd_q[i]) : 64'hdead;
         check($sformatf("%s_fd%0d", tag, i), g, 64'(fd_exp));
      end
      clear_q();
   endtask

   initial begin
      rst_n = 1'b0; val = 1'b0; wrfull = 1'b0;
      sync_x = '0; sync_y = '0; mode = '0; alpha = '0;
      dvi_r = '0; dvi_g = '0; dvi_b = '0; ccd_r = '0; ccd_g = '0; ccd_b = '0;
      #50;
      check("rst_wrreq", 64'(wrreq), 64'd0);
      check("rst_wr_data", 64'(wr_data), 64'd0);
      check("rst_frame_done", 64'(frame_done), 64'd0);
      check("rst_overflow", 64'(overflow), 64'd0);
      @(negedge clk_25) rst_n = 1'b1;
      @(posedge clk_25); #1;

      // Exact 3-cycle latency, DVI-only
      drive(5, 7, 31, 63, 31, 0, 0, 0, 0, 8);
      for (int k = 1; k <= 3; k++) begin
         @(negedge clk_25);
         check($sformatf("lat_wrreq_c%0d", k), 64'(wrreq), 64'(k == 3));
      end
      check("lat_wr_data", 64'(wr_data), 64'(word(5, 7, 31, 63, 31)));
      check("lat_frame_done", 64'(frame_done), 64'd0);
      idle(3);
      clear_q();

      // Blend at frame start, then a mid-frame mode change is ignored
      drive(0, 0, 20, 40, 10, 10, 20, 30, 2, 8);
      drive(1, 0, 20, 40, 10, 10, 20, 30, 1, 8);
      idle(6);
      exp_q.push_back(word(0, 0, 15, 30, 20));
      exp_q.push_back(word(1, 0, 15, 30, 20));
      compare_queue("blend_shadow");

      // Split boundary, then alpha clamp (31 behaves like 16)
      drive(0, 0, 1, 1, 1, 2, 2, 2, 3, 0);
      drive(319, 0, 1, 1, 1, 2, 2, 2, 3, 0);
      drive(320, 0, 1, 1, 1, 2, 2, 2, 3, 0);
      drive(0, 0, 20, 40, 10, 10, 20, 30, 2, 31);
      drive(5, 0, 20, 40, 10, 10, 20, 30, 2, 31);
      drive(0, 0, 20, 40, 10, 10, 20, 30, 2, 16);
      idle(6);
      exp_q.push_back(word(0, 0, 1, 1, 1));
      exp_q.push_back(word(319, 0, 1, 1, 1));
      exp_q.push_back(word(320, 0, 2, 2, 2));
      exp_q.push_back(word(0, 0, 10, 20, 30));
      exp_q.push_back(word(5, 0, 10, 20, 30));
      exp_q.push_back(word(0, 0, 10, 20, 30));
      compare_queue("split_clamp");

      // 10 back-to-back pixels with a 4-cycle stall: nothing written while full, no drop
      wr_while_full = 0;
      for (int i = 0; i < 10; i++) begin
         wrfull = (i >= 2 && i <= 5);
         drive(i, 0, i, 2 * i, 31 - i, 0, 0, 0, 0, 0);
         exp_q.push_back(word(i, 0, i, 2 * i, 31 - i));
      end
      wrfull = 1'b0;
      idle(12);
      check("stall_wr_while_full", 64'(wr_while_full), 64'd0);
      check("stall_overflow", 64'(overflow), 64'd0);
      compare_queue("stall");

      // 7 pixels into a held stall: first 4 kept, remaining 3 dropped
      wrfull = 1'b1;
      for (int i = 0; i < 7; i++) begin
         drive(100 + i, 1, i, i, i, 0, 0, 0, 0, 0);
         if (i < 4) exp_q.push_back(word(100 + i, 1, i, i, i));
      end
      idle(5);
      check("ovf_held_count", 64'(got_q.size()), 64'd0);
      check("ovf_set", 64'(overflow), 64'd1);
      wrfull = 1'b0;
      idle(8);
      compare_queue("ovf");
      check("ovf_sticky", 64'(overflow), 64'd1);

      // frame_done on the last pixel of the frame only
      drive(638, 479, 1, 2, 3, 0, 0, 0, 0, 0);
      drive(639, 479, 3, 4, 5, 0, 0, 0, 0, 0);
      idle(6);
      exp_q.push_back(word(638, 479, 1, 2, 3));
      exp_q.push_back(word(639, 479, 3, 4, 5));
      compare_queue("frame");

      // Reset with 3 words buffered: everything discarded
      wrfull = 1'b1;
      drive(50, 2, 1, 1, 1, 0, 0, 0, 0, 0);
      drive(51, 2, 1, 1, 1, 0, 0, 0, 0, 0);
      drive(52, 2, 1, 1, 1, 0, 0, 0, 0, 0);
      idle(4);
      clear_q();
      rst_n = 1'b0;
      #5;
      check("mrst_wrreq", 64'(wrreq), 64'd0);
      check("mrst_wr_data", 64'(wr_data), 64'd0);
      check("mrst_overflow", 64'(overflow), 64'd0);
      @(negedge clk_25) rst_n = 1'b1;
      wrfull = 1'b0;
      @(posedge clk_25); #1;
      idle(10);
      check("mrst_no_writes", 64'(got_q.size()), 64'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule

// File: doc/blend_writer.md
Name: blend_writer

Overview:
- Downstream of the sync controller.
- Consumes its per-pixel stream: val, sync_x/y, DVI RGB565 and CCD RGB565.
- Composites each DVI/CCD pixel pair according to mode/alpha and packs the result with its coordinates into 36-bit words for the frame-buffer write FIFO (dc FIFO, write side on clk_25).
- Absorbs the upstream stream, which has no backpressure, with an internal skid FIFO, and flags overflow and frame completion.

Parameters:
- H_ACT, 640, active pixels per line; last x = H_ACT-1.
- V_ACT, 480, active lines per frame; last y = V_ACT-1.
- DEPTH, 4, skid FIFO entries (power of 2, >=2).

Ports:
- clk_25  in  1  pixel clock; all logic on rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- val  in  1  pixel strobe, single-cycle per pixel, no backpressure.
- sync_x  in  10  pixel x coordinate.
- sync_y  in  10  pixel y coordinate.
- dvi_r/dvi_g/dvi_b  in  5/6/5  DVI pixel.
- ccd_r/ccd_g/ccd_b  in  5/6/5  CCD (warped) pixel.
- mode  in  2  0=DVI only, 1=CCD only, 2=alpha blend, 3=split (x<H_ACT/2 DVI, else CCD).
- alpha  in  5  CCD weight in 1/16 steps; values >16 clamp to 16.
- wrfull  in  1  write FIFO almost-full; asserted with >=1 free entry remaining.
- wrclk  out  1  = clk_25.
- wrreq  out  1  write strobe to FIFO.
- wr_data  out  36  {x[9:0], y[9:0], r[4:0], g[5:0], b[4:0]}.
- frame_done  out  1  one-cycle pulse coincident with wrreq of pixel (H_ACT-1, V_ACT-1).
- overflow  out  1  sticky; set when a pixel is dropped.

Behaviour:
- Reset: wrreq=0, wr_data=0, frame_done=0, overflow=0, FIFO empty, pipeline valids=0, shadow mode=0, shadow alpha=0.
- Shadow controls: mode/alpha are copied into shadow registers only when val=1 with sync_x=0, sync_y=0. That pixel itself uses the new values. All other pixels use the shadows, so settings never change mid-frame.
- Stage 1 (cycle n+1): register coordinates, both pixels and the valid bit. Form per-channel products:
  - dvi_c*(16-a) and ccd_c*a, where a = min(alpha,16).
  - Widths: R/B 5x5 -> 10b, G 6x5 -> 11b.
- Stage 2 (cycle n+2): select per mode.
  - Blend: c = (dvi_c*(16-a) + ccd_c*a) >> 4, truncating. Sum <= 31*16 (R/B) or 63*16 (G); no overflow, no saturation needed.
  - a=0 gives exactly DVI; a=16 gives exactly CCD.
  - Split: compare sync_x < H_ACT/2 (320).
- Output register (cycle n+3), evaluated each edge:
  - If wrfull=1: wrreq<=0, wr_data holds.
  - Else if FIFO non-empty: pop head into wr_data, wrreq<=1.
  - Else if stage-2 valid: bypass stage 2 into wr_data, wrreq<=1.
  - Else: wrreq<=0.
  - Minimum latency val -> wrreq = 3 cycles. Order is always preserved.
- Skid FIFO push: stage-2 valid and not bypassed. Push and pop may happen in the same cycle; count unchanged.
- Overflow: FIFO full, push requested and no pop that cycle -> drop the stage-2 pixel and set overflow=1. Overflow clears only on reset. Push while full with a simultaneous pop is not a drop.
- frame_done: registered alongside wrreq when the word written has x=H_ACT-1 and y=V_ACT-1.
- Coordinates pass through unmodified. Out-of-range coordinates are written as-is; no wrap checking.
- Reset mid-operation discards pipeline and FIFO contents; nothing is written after rst_n is released until a new val arrives.

Test Plan:
- mode=0, alpha=8, val at (5,7), dvi=(31,63,31), ccd=(0,0,0), wrfull=0 -> wrreq exactly 3 cycles later, wr_data={5,7,31,63,31}, frame_done=0.
- Frame-start pixel (0,0) with mode=2, alpha=8, dvi=(20,40,10), ccd=(10,20,30) -> wr_data colour (15,30,20). Then mode=1 applied at pixel (1,0) -> ignored, output still blended (shadow held).
- Split mode: pixels at x=319 and x=320, dvi=(1,1,1), ccd=(2,2,2) -> colours (1,1,1) then (2,2,2). alpha=31 in blend -> identical to alpha=16 (pure CCD).
- Back-to-back val for 10 cycles with wrfull held high for cycles 2..5 -> no words written while wrfull is high. All 10 words then emerge in order with no drop; overflow=0.
- wrfull held high while 7 consecutive pixels arrive (DEPTH=4) -> overflow=1. The first 4 pixels beyond the stage-2 bypass path are retained and written in order after wrfull drops; the remaining pixels are lost.
- Pixel (639,479) -> frame_done high in the same cycle as its wrreq. Assert rst_n=0 with 3 words buffered -> wrreq=0 and FIFO empty; no writes after release.
